seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle sign-magnitude integer divider for the calculator datapath; parametrised successor of the combinational divider.
//  Restoring algorithm, one quotient bit per clock, start/done handshake; registered quotient, remainder, sign and error flags.
//  Sits between the operand/operator capture logic and the display formatter.
// PARAMETERS
//  WIDTH     8   operand, quotient and remainder magnitude width (>=2)
//  CNT_W     $clog2(WIDTH+1)   iteration counter width (localparam, not overridable)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only when busy==0
//  A          in   WIDTH  dividend magnitude
//  B          in   WIDTH  divisor magnitude
//  Asign      in   1      dividend sign (1 = negative)
//  Bsign      in   1      divisor sign (1 = negative)
//  busy       out  1      operation in progress
//  done       out  1      one-cycle pulse: results valid
//  Res        out  WIDTH  quotient magnitude
//  Remainder  out  WIDTH  remainder magnitude
//  negative   out  1      quotient sign
//  rem_neg    out  1      remainder sign
//  error      out  1      divide-by-zero flag
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error, negative, rem_neg = 0; Res, Remainder = 0. Mid-operation reset aborts without emitting done.
//  FSM IDLE -> BUSY -> DONE -> IDLE (or DONE -> BUSY on start).
//  Accept at edge k when start=1 and busy=0 (IDLE or DONE):
//   - latch A, B, Asign, Bsign
//   - clear partial remainder (WIDTH+1 bits)
//   - counter = WIDTH
//   - busy=1
//  BUSY: each edge performs one restoring step:
//   - p = {p[WIDTH-1:0], a_msb}; a shifts left
//   - trial = p - B; if trial non-negative, p = trial and q bit = 1, else q bit = 0
//   - counter decrements
//  Edge k+WIDTH performs the last step, registers outputs, enters DONE. done=1 for exactly that one cycle; busy=0 in it.
//  Latency: WIDTH cycles from the accepting edge to done. Back-to-back start in the DONE cycle is accepted.
//  Outputs hold until the next done; busy stays 0 in IDLE.
//  start while busy=1 is ignored; operand changes while busy are ignored.
//  Sign rules (truncation toward zero):
//   - negative = Asign ^ Bsign, forced 0 when Res == 0
//   - rem_neg = Asign, forced 0 when Remainder == 0
//  Remainder is the final partial remainder; no multiplier. Invariant: A = Res*B + Remainder, Remainder < B.
//  B == 0:
//   - error=1, Res = all ones, Remainder = A, negative = 0, rem_neg = 0
//   - error clears on the next accepted non-zero-divisor operation
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: B==0 detected at accept; FSM goes straight to DONE; done pulses 1 cycle after the accepting edge with the error outputs above.
//  Undefined: B==0 runs the full WIDTH iterations (the restoring step naturally yields all-ones quotient, remainder A). done at WIDTH latency; error set with results.
// STRUCTURE
//  Package calc_div_pkg: state typedef (IDLE/BUSY/DONE), state encoding constants.
//  Sub-module div_step: combinational single restoring step (shift-in bit, trial subtract, select); parametrised by WIDTH.
//  Top: FSM, counter, operand/result registers, sign and zero-fix logic.
// TESTING (WIDTH=8)
//  1. A=100,B=7, signs 0/0, start -> done 8 cycles later; Res=14, Remainder=2, negative=0, rem_neg=0, error=0.
//  2. A=100,Asign=1,B=7,Bsign=0 -> Res=14, negative=1, Remainder=2, rem_neg=1; A=6,Asign=1,B=7 -> Res=0, negative=0.
//  3. A=5,B=0 -> error=1, Res=255, Remainder=5. Done at cycle 1 with DIV_ZERO_FAST_EN, cycle 8 without.
//  4. A=255,B=1 then start in DONE cycle with A=200,B=16 -> Res=255 rem 0, then 8 cycles later Res=12 rem 8, error=0.
//  5. start again 3 cycles into an op with new operands -> ignored; done after 8 cycles with original results.
//  6. reset_n low at cycle 4 of an op -> all outputs 0 immediately, no done pulse; fresh op afterwards correct.
//  Plus random sweep of all A,B in 0..255 against the invariant A = Res*B + Remainder.

Source files
------------

// File: rtl/calc_div_pkg.sv
// Shared definitions for the sequential sign-magnitude divider: FSM state
// type and its encoding constants.
package calc_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep the
// difference only when it did not borrow.
module div_step
    import calc_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The partial remainder entering a step is always below the divisor, so
    // its top bit is zero and is dropped by the shift.
    logic unused_p_msb;
    assign unused_p_msb = p_in[WIDTH];

    // Shift, trial subtract with a borrow bit, then restore or keep.
    always_comb begin
        shifted = {p_in[WIDTH-1:0], bit_in};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        p_out   = q_bit ? trial[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle sign-magnitude restoring divider, one quotient bit per clock,
// with a start/done handshake and registered results.
// Optional build macro: DIV_ZERO_FAST_EN -- when defined, a zero divisor is
// detected at accept and the result is produced one cycle later instead of
// after the full WIDTH iterations.
module seq_divider
    import calc_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Asign,
    input  logic             Bsign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] Remainder,
    output logic             negative,
    output logic             rem_neg,
    output logic             error
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;       // dividend, shifts left; quotient bits fill from the LSB
    logic [WIDTH-1:0]   b_q;
    logic               asign_q;
    logic               bsign_q;
    logic [WIDTH:0]     p_q;       // partial remainder
    logic [WIDTH:0]     p_next;
    logic               q_bit;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               last_step;
    logic               b_zero;
    logic               zero_fast;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;

    assign busy       = (state_q == BUSY);
    assign done       = (state_q == DONE);
    assign accept     = start && (state_q != BUSY);
    assign last_step  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    assign b_zero     = (b_q == '0);
    assign quot_final = {a_q[WIDTH-2:0], q_bit};
    assign rem_final  = p_next[WIDTH-1:0];

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = (B == '0);
`else
    assign zero_fast = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in    (p_q),
        .bit_in  (a_q[WIDTH-1]),
        .divisor (b_q),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = zero_fast ? DONE : BUSY;
            end
            BUSY: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (accept) state_d = zero_fast ? DONE : BUSY;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: datapath registers are reset as well, because the outputs must
        // read zero immediately on reset and an abort must leave nothing stale.
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            asign_q   <= 1'b0;
            bsign_q   <= 1'b0;
            p_q       <= '0;
            cnt_q     <= '0;
            Res       <= '0;
            Remainder <= '0;
            negative  <= 1'b0;
            rem_neg   <= 1'b0;
            error     <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            asign_q <= Asign;
            bsign_q <= Bsign;
            p_q     <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            if (zero_fast) begin
                Res       <= '1;
                Remainder <= A;
                negative  <= 1'b0;
                rem_neg   <= 1'b0;
                error     <= 1'b1;
            end
        end else if (state_q == BUSY) begin
            p_q   <= p_next;
            a_q   <= {a_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                // A zero divisor naturally yields all-ones quotient and
                // remainder A; only the sign flags need forcing.
                Res       <= quot_final;
                Remainder <= rem_final;
                negative  <= (asign_q ^ bsign_q) && (quot_final != '0) && !b_zero;
                rem_neg   <= asign_q && (rem_final != '0) && !b_zero;
                error     <= b_zero;
            end
        end
    end

endmodule
